inst_queue: RTL and testbench

INST_QUEUE -- requirements
Module: inst_queue

---
 rtl/inst_queue.sv | 126 ++++++++++++
 tb/tb_inst_queue.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// inst_queue -- dual-issue instruction queue between fetch and decode.
//
// Circular buffer of DEPTH {inst, pc} entries. Fetch pushes up to two
// instructions per cycle (slot1 only together with slot0); decode pops up to
// two per cycle from the head. Outputs show the two oldest entries
// combinationally from storage, so a write becomes visible one cycle later.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   flush               discard all contents (wins over same-cycle enq/deq)
//   in_valid[1:0]       fetch slot valids (2'b10 is ignored)
//   in_inst0/1, in_pc   fetched words; slot1 PC is in_pc + 4
//   in_ready            room for two entries (count <= DEPTH-2)
//   out_valid[1:0]      head-entry valids, bit0 = oldest
//   out_inst0/1,
//   out_pc0/1           two oldest entries
//   deq[1:0]            decode consume request 0..3 (3 behaves as 2)
//   count, full, empty  occupancy status
module inst_queue #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [1:0]               in_valid,
    input  logic [WIDTH-1:0]         in_inst0,
    input  logic [WIDTH-1:0]         in_inst1,
    input  logic [WIDTH-1:0]         in_pc,
    output logic                     in_ready,
    output logic [1:0]               out_valid,
    output logic [WIDTH-1:0]         out_inst0,
    output logic [WIDTH-1:0]         out_inst1,
    output logic [WIDTH-1:0]         out_pc0,
    output logic [WIDTH-1:0]         out_pc1,
    input  logic [1:0]               deq,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW        = $clog2(DEPTH);
    localparam int CW        = PW + 1;
    localparam int NUM_LANES = 2;

    typedef struct packed {
        logic [WIDTH-1:0] inst;
        logic [WIDTH-1:0] pc;
    } entry_t;

    entry_t mem [DEPTH];

    logic [PW-1:0] head, tail;
    logic [CW-1:0] count_q;
    logic [1:0]    nenq, ndeq, nvld, deq_req;

    entry_t [NUM_LANES-1:0]         wr_ent;
    logic   [NUM_LANES-1:0]         wr_en;
    logic   [NUM_LANES-1:0][PW-1:0] wr_ptr;

    entry_t rd0, rd1;

    // Readiness depends on registered occupancy only, so fetch never sees a
    // combinational path from decode's consume request.
    assign in_ready = (count_q <= CW'(DEPTH - 2));

    always_comb begin
        nenq = 2'd0;
        if (in_ready) begin
            if (in_valid == 2'b11)      nenq = 2'd2;
            else if (in_valid == 2'b01) nenq = 2'd1;
        end

        if (count_q == '0)            nvld = 2'd0;
        else if (count_q == CW'(1))   nvld = 2'd1;
        else                          nvld = 2'd2;

        deq_req = (deq == 2'd3) ? 2'd2 : deq;
        ndeq    = (deq_req > nvld) ? nvld : deq_req;
    end

    // Two write lanes; power-of-2 depth makes tail+1 wrap for free.
    always_comb begin
        wr_ent[0] = '{inst: in_inst0, pc: in_pc};
        wr_ent[1] = '{inst: in_inst1, pc: in_pc + WIDTH'(4)};
        wr_ptr[0] = tail;
        wr_ptr[1] = tail + PW'(1);
        wr_en[0]  = !flush && (nenq != 2'd0);
        wr_en[1]  = !flush && (nenq == 2'd2);
    end

    // Storage is not reset; count/out_valid decide what is meaningful.
    always_ff @(posedge clk) begin
        for (int l = 0; l < NUM_LANES; l++) begin
            if (wr_en[l]) mem[wr_ptr[l]] <= wr_ent[l];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            head    <= head + PW'(ndeq);
            tail    <= tail + PW'(nenq);
            count_q <= count_q + CW'(nenq) - CW'(ndeq);
        end
    end

    assign rd0 = mem[head];
    assign rd1 = mem[head + PW'(1)];

    assign out_inst0 = rd0.inst;
    assign out_pc0   = rd0.pc;
    assign out_inst1 = rd1.inst;
    assign out_pc1   = rd1.pc;

    assign out_valid = (nvld == 2'd0) ? 2'b00 : (nvld == 2'd1) ? 2'b01 : 2'b11;
    assign count     = count_q;
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;
    localparam int DEPTH = 8;
    localparam int WIDTH = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 0;
    logic             rst = 0;
    logic             flush = 0;
    logic [1:0]       in_valid = 0;
    logic [WIDTH-1:0] in_inst0 = 0, in_inst1 = 0, in_pc = 0;
    logic             in_ready;
    logic [1:0]       out_valid;
    logic [WIDTH-1:0] out_inst0, out_inst1, out_pc0, out_pc1;
    logic [1:0]       deq = 0;
    logic [CW-1:0]    count;
    logic             full, empty;

    int checks = 0;
    int errors = 0;

    // Reference model: a plain FIFO of instruction words and their PCs.
    logic [WIDTH-1:0] mq_inst[$];
    logic [WIDTH-1:0] mq_pc[$];

    inst_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_inst0(in_inst0), .in_inst1(in_inst1), .in_pc(in_pc),
        .in_ready(in_ready), .out_valid(out_valid),
        .out_inst0(out_inst0), .out_inst1(out_inst1),
        .out_pc0(out_pc0), .out_pc1(out_pc1),
        .deq(deq), .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus at the falling edge, let the rising edge
    // happen, update the model with the same rules, return at the next
    // falling edge where outputs are sampled.
    task automatic cycle(input logic [1:0] v, input logic [WIDTH-1:0] i0,
                         input logic [WIDTH-1:0] i1, input logic [WIDTH-1:0] pc,
                         input logic [1:0] d, input logic fl);
        int sz, want, ne, nd;
        in_valid = v; in_inst0 = i0; in_inst1 = i1; in_pc = pc; deq = d; flush = fl;
        sz   = mq_inst.size();
        ne   = (sz <= DEPTH - 2) ? ((v == 2'b11) ? 2 : (v == 2'b01) ? 1 : 0) : 0;
        want = (d == 2'd3) ? 2 : int'(d);
        nd   = (want < sz) ? want : ((sz < 2) ? sz : 2);
        @(posedge clk);
        if (fl) begin
            mq_inst.delete(); mq_pc.delete();
        end else begin
            repeat (nd) begin void'(mq_inst.pop_front()); void'(mq_pc.pop_front()); end
            if (ne >= 1) begin mq_inst.push_back(i0); mq_pc.push_back(pc); end
            if (ne == 2) begin mq_inst.push_back(i1); mq_pc.push_back(pc + 4); end
        end
        @(negedge clk);
        in_valid = 0; deq = 0; flush = 0;
    endtask

    task automatic do_flush();
        cycle(2'b00, 0, 0, 0, 2'd0, 1'b1);
    endtask

    task automatic test_reset();
        rst = 1;
        #3;
        checks++;
        if (count !== 0 || out_valid !== 2'b00 || empty !== 1'b1 || full !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: count=%0d out_valid=%b empty=%b full=%b in_ready=%b, want 0 00 1 0 1",
                     count, out_valid, empty, full, in_ready);
        end
        @(negedge clk);
        rst = 0;
        mq_inst.delete(); mq_pc.delete();
    endtask

    task automatic test_basic();
        cycle(2'b11, 32'hA, 32'hB, 32'h100, 2'd0, 1'b0);
        checks++;
        if (count !== 2 || out_valid !== 2'b11) begin
            errors++;
            $display("FAIL basic_status: count=%0d out_valid=%b, want 2 11", count, out_valid);
        end
        checks++;
        if (out_inst0 !== 32'hA || out_inst1 !== 32'hB || out_pc0 !== 32'h100 || out_pc1 !== 32'h104) begin
            errors++;
            $display("FAIL basic_data: %h %h %h %h, want a b 100 104", out_inst0, out_inst1, out_pc0, out_pc1);
        end
    endtask

    task automatic test_fill();
        // From count 2: one single, then pairs until ready drops at 7.
        cycle(2'b01, 32'hC, 32'h0, 32'h108, 2'd0, 1'b0);
        cycle(2'b11, 32'hD, 32'hE, 32'h10C, 2'd0, 1'b0);
        cycle(2'b11, 32'hF, 32'h10, 32'h114, 2'd0, 1'b0);
        checks++;
        if (count !== 7 || in_ready !== 1'b0 || full !== 1'b0) begin
            errors++;
            $display("FAIL fill_odd: count=%0d in_ready=%b full=%b, want 7 0 0", count, in_ready, full);
        end
        cycle(2'b11, 32'h11, 32'h12, 32'h11C, 2'd0, 1'b0);
        checks++;
        if (count !== 7 || out_inst0 !== 32'hA) begin
            errors++;
            $display("FAIL fill_ignore: count=%0d out_inst0=%h, want 7 a", count, out_inst0);
        end
        // Even fill reaches exactly DEPTH.
        do_flush();
        for (int k = 0; k < DEPTH / 2; k++)
            cycle(2'b11, 32'h20 + k * 2, 32'h21 + k * 2, 32'h200 + k * 8, 2'd0, 1'b0);
        checks++;
        if (count !== DEPTH || full !== 1'b1 || in_ready !== 1'b0 || empty !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: count=%0d full=%b in_ready=%b, want 8 1 0", count, full, in_ready);
        end
        cycle(2'b11, 32'h99, 32'h98, 32'h900, 2'd0, 1'b0);
        checks++;
        if (count !== DEPTH || out_inst0 !== 32'h20 || out_pc1 !== 32'h204) begin
            errors++;
            $display("FAIL full_ignore: count=%0d out_inst0=%h out_pc1=%h, want 8 20 204",
                     count, out_inst0, out_pc1);
        end
    endtask

    task automatic test_partial_deq();
        do_flush();
        cycle(2'b01, 32'h55, 32'h0, 32'h400, 2'd0, 1'b0);
        cycle(2'b11, 32'h66, 32'h77, 32'h404, 2'd2, 1'b0);
        checks++;
        if (count !== 2 || out_inst0 !== 32'h66 || out_inst1 !== 32'h77 || out_pc0 !== 32'h404) begin
            errors++;
            $display("FAIL partial_deq: count=%0d inst0=%h inst1=%h pc0=%h, want 2 66 77 404",
                     count, out_inst0, out_inst1, out_pc0);
        end
        // deq==3 behaves as 2
        cycle(2'b00, 0, 0, 0, 2'd3, 1'b0);
        checks++;
        if (count !== 0 || out_valid !== 2'b00) begin
            errors++;
            $display("FAIL deq3: count=%0d out_valid=%b, want 0 00", count, out_valid);
        end
    endtask

    task automatic test_flush();
        do_flush();
        cycle(2'b11, 1, 2, 32'h500, 2'd0, 1'b0);
        cycle(2'b11, 3, 4, 32'h508, 2'd0, 1'b0);
        cycle(2'b01, 5, 0, 32'h510, 2'd0, 1'b0);
        checks++;
        if (count !== 5) begin
            errors++;
            $display("FAIL flush_setup: count=%0d, want 5", count);
        end
        cycle(2'b11, 6, 7, 32'h514, 2'd2, 1'b1);
        checks++;
        if (count !== 0 || empty !== 1'b1 || out_valid !== 2'b00) begin
            errors++;
            $display("FAIL flush: count=%0d empty=%b out_valid=%b, want 0 1 00", count, empty, out_valid);
        end
    endtask

    task automatic test_random();
        int sz;
        logic [1:0] v;
        do_flush();
        for (int n = 0; n < 80; n++) begin
            v = 2'($urandom_range(0, 3));
            cycle(v, $urandom, $urandom, {$urandom_range(0, 32'hFFFF), 2'b00},
                  2'($urandom_range(0, 3)), ($urandom_range(0, 40) == 0));
            sz = mq_inst.size();
            checks++;
            if (int'(count) != sz || count > DEPTH || empty !== (sz == 0) || full !== (sz == DEPTH)
                || in_ready !== (sz <= DEPTH - 2)) begin
                errors++;
                $display("FAIL rand_status[%0d]: count=%0d empty=%b full=%b ready=%b, want count %0d",
                         n, count, empty, full, in_ready, sz);
            end
            checks++;
            if (out_valid !== ((sz == 0) ? 2'b00 : (sz == 1) ? 2'b01 : 2'b11)) begin
                errors++;
                $display("FAIL rand_valid[%0d]: out_valid=%b size=%0d", n, out_valid, sz);
            end
            if (sz >= 1) begin
                checks++;
                if (out_inst0 !== mq_inst[0] || out_pc0 !== mq_pc[0]) begin
                    errors++;
                    $display("FAIL rand_head0[%0d]: %h/%h, want %h/%h", n, out_inst0, out_pc0, mq_inst[0], mq_pc[0]);
                end
            end
            if (sz >= 2) begin
                checks++;
                if (out_inst1 !== mq_inst[1] || out_pc1 !== mq_pc[1]) begin
                    errors++;
                    $display("FAIL rand_head1[%0d]: %h/%h, want %h/%h", n, out_inst1, out_pc1, mq_inst[1], mq_pc[1]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        do_flush();
        for (int k = 0; k < 3; k++) cycle(2'b11, k, k + 10, 32'h600 + k * 8, 2'd0, 1'b0);
        checks++;
        if (count !== 6) begin
            errors++;
            $display("FAIL areset_setup: count=%0d, want 6", count);
        end
        #2 rst = 1;
        #1;
        checks++;
        if (count !== 0 || out_valid !== 2'b00 || empty !== 1'b1 || full !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL areset_async: count=%0d out_valid=%b empty=%b ready=%b, want 0 00 1 1",
                     count, out_valid, empty, in_ready);
        end
        #1 rst = 0;
        mq_inst.delete(); mq_pc.delete();
        @(negedge clk);
        cycle(2'b10, 32'h77, 32'h78, 32'h700, 2'd0, 1'b0);
        checks++;
        if (count !== 0 || out_valid !== 2'b00) begin
            errors++;
            $display("FAIL slot1_only: count=%0d out_valid=%b, want 0 00", count, out_valid);
        end
        cycle(2'b01, 32'h79, 32'h0, 32'h704, 2'd0, 1'b0);
        checks++;
        if (count !== 1 || out_inst0 !== 32'h79 || out_pc0 !== 32'h704) begin
            errors++;
            $display("FAIL post_reset_enq: count=%0d inst0=%h pc0=%h, want 1 79 704", count, out_inst0, out_pc0);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_fill();
        test_partial_deq();
        test_flush();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
